// File: rtl/rect_pkg.sv
// Shared definitions for the rectangle command link: packet layout,
// serializer state encoding and the byte-3 field packing used by both ends.
package rect_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         PKT_LEN        = 7;

    // Byte 3 layout: {color[5:0], x2[8], x1[8]}
    localparam int B3_X1H       = 0;
    localparam int B3_X2H       = 1;
    localparam int B3_COLOR_LSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    typedef struct packed {
        logic [8:0] x1;
        logic [8:0] x2;
        logic [7:0] y1;
        logic [7:0] y2;
        logic [5:0] color;
    } rect_cmd_t;

    function automatic logic [7:0] pack_b3(input rect_cmd_t c);
        logic [7:0] b;
        b                      = '0;
        b[B3_X1H]              = c.x1[8];
        b[B3_X2H]              = c.x2[8];
        b[B3_COLOR_LSB +: 6]   = c.color;
        return b;
    endfunction

    function automatic logic [7:0] pkt_byte(
        input logic [2:0] idx,
        input rect_cmd_t  c,
        input logic [7:0] hdr
    );
        logic [7:0] b3;
        logic [7:0] cks;
        b3  = pack_b3(c);
        cks = c.x1[7:0] ^ c.x2[7:0] ^ b3 ^ c.y1 ^ c.y2;
        unique case (idx)
            3'd0:    return hdr;
            3'd1:    return c.x1[7:0];
            3'd2:    return c.x2[7:0];
            3'd3:    return b3;
            3'd4:    return c.y1;
            3'd5:    return c.y2;
            3'd6:    return cks;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer. A load on the last stop-bit cycle chains the
// next byte with no idle gap; last flags that final cycle.
module uart_tx_byte
    import rect_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       last
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t      state, state_nx;
    logic [BW-1:0]  baud, baud_nx;
    logic [2:0]     bit_idx, bit_nx;
    logic [7:0]     shreg, shreg_nx;
    logic           bit_end;

    assign bit_end = (baud == BW'(CLKS_PER_BIT - 1));
    assign busy    = (state != ST_IDLE);
    assign last    = (state == ST_STOP) && bit_end;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            baud    <= baud_nx;
            bit_idx <= bit_nx;
            shreg   <= shreg_nx;
        end
    end

    always_comb begin
        state_nx = state;
        baud_nx  = baud;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        tx       = 1'b1;
        unique case (state)
            ST_IDLE: begin
                if (load) begin
                    state_nx = ST_START;
                    baud_nx  = '0;
                    bit_nx   = '0;
                    shreg_nx = data;
                end
            end
            ST_START: begin
                tx      = 1'b0;
                baud_nx = baud + 1'b1;
                if (bit_end) begin
                    baud_nx  = '0;
                    bit_nx   = '0;
                    state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                tx      = shreg[bit_idx];
                baud_nx = baud + 1'b1;
                if (bit_end) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) begin
                        bit_nx   = '0;
                        state_nx = ST_STOP;
                    end else begin
                        bit_nx = bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                tx      = 1'b1;
                baud_nx = baud + 1'b1;
                if (bit_end) begin
                    baud_nx = '0;
                    if (load) begin
                        state_nx = ST_START;
                        shreg_nx = data;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/rect_uart_tx.sv
// Rectangle command transmitter: captures a draw command and streams it
// as a 7-byte UART packet (header, fields, XOR checksum).
module rect_uart_tx
    import rect_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] x1,
    input  logic [8:0] x2,
    input  logic [7:0] y1,
    input  logic [7:0] y2,
    input  logic [5:0] color,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] byte_num
);

    rect_cmd_t  cmd;
    logic [2:0] byte_q;
    logic [2:0] next_idx;
    logic       accept;
    logic       step;
    logic       final_byte;
    logic       ser_load;
    logic       ser_last;
    logic [7:0] ser_data;

    assign accept     = start && !busy && !reset;
    assign step       = ser_last;
    assign final_byte = (byte_q == 3'(PKT_LEN - 1));
    assign next_idx   = byte_q + 3'd1;
    assign done       = step && final_byte;
    assign byte_num   = byte_q;

    // Header goes out straight from the accept cycle; later bytes come
    // from the captured command so input changes cannot leak in.
    assign ser_load = accept || (step && !final_byte);
    assign ser_data = accept ? HEADER : pkt_byte(next_idx, cmd, HEADER);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cmd    <= '0;
            byte_q <= '0;
        end else if (accept) begin
            cmd.x1    <= x1;
            cmd.x2    <= x2;
            cmd.y1    <= y1;
            cmd.y2    <= y2;
            cmd.color <= color;
            byte_q    <= '0;
        end else if (step) begin
            byte_q <= final_byte ? 3'd0 : next_idx;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .load    (ser_load),
        .data    (ser_data),
        .tx      (tx),
        .busy    (busy),
        .last    (ser_last)
    );

endmodule

// File: tb/tb_rect_uart_tx.sv
// Scoreboard bench for rect_uart_tx at CLKS_PER_BIT=4: stimulus queues
// hand-computed packet bytes, a monitor checks every line cycle.
module tb_rect_uart_tx;

    localparam int CPB = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic [8:0] x1       = '0;
    logic [8:0] x2       = '0;
    logic [7:0] y1       = '0;
    logic [7:0] y2       = '0;
    logic [5:0] color    = '0;
    logic       tx;
    logic       busy;
    logic       done;
    logic [2:0] byte_num;

    rect_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .HEADER      (8'hA5)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .start   (start),
        .x1      (x1),
        .x2      (x2),
        .y1      (y1),
        .y2      (y2),
        .color   (color),
        .tx      (tx),
        .busy    (busy),
        .done    (done),
        .byte_num(byte_num)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    logic [7:0] exp_q[$];
    int         n_chk     = 0;
    int         n_pass    = 0;
    int         exp_done  = 0;
    int         done_cnt  = 0;
    int         cyc       = 0;
    bit         mon_en    = 1'b1;

    logic [7:0] v1 [7] = '{8'hA5, 8'hC8, 8'h2C, 8'hCE, 8'h32, 8'h64, 8'h7C};
    logic [7:0] v2 [7] = '{8'hA5, 8'h05, 8'h03, 8'hFC, 8'hC8, 8'h0A, 8'h38};
    logic [7:0] v3 [7] = '{8'hA5, 8'hFF, 8'h00, 8'h03, 8'hFF, 8'h00, 8'h03};

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) if (done === 1'b1) done_cnt++;

    initial begin
        repeat (50000) @(posedge CLOCK_50);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // Monitor: checks every cycle of every bit of a queued packet
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (mon_en && !reset && tx === 1'b0) begin
                if (exp_q.size() < 7) begin
                    check(1'b0, "unexpected_packet", exp_q.size(), 7);
                end else begin
                    for (int b = 0; b < 7; b++) begin
                        logic [7:0] d;
                        logic [9:0] frame;
                        int errs;
                        errs  = 0;
                        d     = exp_q.pop_front();
                        frame = {1'b1, d, 1'b0};
                        for (int k = 0; k < 10; k++) begin
                            for (int c = 0; c < CPB; c++) begin
                                bit lst;
                                if (b != 0 || k != 0 || c != 0)
                                    @(negedge CLOCK_50);
                                lst = (b == 6 && k == 9 && c == CPB - 1);
                                if (tx !== frame[k]) errs++;
                                if (busy !== 1'b1) errs++;
                                if (byte_num !== 3'(b)) errs++;
                                if (done !== lst) errs++;
                            end
                        end
                        check(errs == 0, $sformatf("byte%0d_%02h", b, d),
                              errs, 0);
                    end
                    @(negedge CLOCK_50);
                    check(busy === 1'b0 && done === 1'b0 && byte_num == 0,
                          "post_packet_idle", {busy, done, byte_num}, 0);
                end
            end
        end
    end

    task automatic send(input logic [8:0] a1, input logic [8:0] a2,
                        input logic [7:0] b1, input logic [7:0] b2,
                        input logic [5:0] c, input logic [7:0] ex [7],
                        input bit push);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(busy === 1'b0, "send_ready", busy, 0);
        x1 = a1; x2 = a2; y1 = b1; y2 = b2; color = c;
        start = 1'b1;
        if (push) begin
            for (int i = 0; i < 7; i++) exp_q.push_back(ex[i]);
            exp_done++;
        end
        @(negedge CLOCK_50);
        start = 1'b0;
        check(busy === 1'b1 && tx === 1'b0, "accept_start_bit",
              {busy, tx}, 2'b10);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 1000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(done === 1'b1, "done_seen", done, 1);
    endtask

    initial begin
        int d;
        int errs;
        repeat (3) @(negedge CLOCK_50);
        check(tx === 1'b1 && busy === 1'b0 && done === 1'b0 &&
              byte_num === 3'd0, "reset_state",
              {tx, busy, done, byte_num}, 6'b100000);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        // Packet 1 with an ignored start about 100 cycles in
        send(9'd200, 9'd300, 8'd50, 8'd100, 6'h33, v1, 1'b1);
        repeat (98) @(negedge CLOCK_50);
        x1 = 9'd7; x2 = 9'd9; y1 = 8'd1; y2 = 8'd2; color = 6'h01;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        wait_done();
        repeat (20) @(negedge CLOCK_50);
        check(done_cnt == 1, "single_done", done_cnt, 1);
        check(exp_q.size() == 0, "queue_drained_1", exp_q.size(), 0);

        // Inverted bounds, then back-to-back extreme values
        send(9'd5, 9'd3, 8'd200, 8'd10, 6'h3F, v2, 1'b1);
        wait_done();
        d = cyc;
        send(9'd511, 9'd256, 8'd255, 8'd0, 6'h00, v3, 1'b1);
        check(cyc == d + 2, "back_to_back_gap", cyc - d, 2);
        wait_done();
        repeat (5) @(negedge CLOCK_50);

        // Reset mid-packet
        mon_en = 1'b0;
        send(9'd200, 9'd300, 8'd50, 8'd100, 6'h33, v1, 1'b0);
        repeat (148) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        check(tx === 1'b1 && busy === 1'b0, "reset_abort",
              {tx, busy}, 2'b10);
        reset = 1'b0;
        errs = 0;
        repeat (300) begin
            @(negedge CLOCK_50);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
        end
        check(errs == 0, "abort_no_resume", errs, 0);
        check(done_cnt == exp_done, "abort_no_done", done_cnt, exp_done);
        mon_en = 1'b1;
        send(9'd200, 9'd300, 8'd50, 8'd100, 6'h33, v1, 1'b1);
        wait_done();
        repeat (5) @(negedge CLOCK_50);

        // Start together with reset
        reset = 1'b1;
        start = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        start = 1'b0;
        errs = 0;
        repeat (50) begin
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
            @(negedge CLOCK_50);
        end
        check(errs == 0, "reset_beats_start", errs, 0);

        check(exp_q.size() == 0, "queue_drained_end", exp_q.size(), 0);
        check(done_cnt == exp_done, "done_count", done_cnt, exp_done);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rect_uart_tx.md
RECT_UART_TX -- requirements
Module: rect_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, CLOCK_50 cycles per UART bit (115200 baud at 50 MHz); legal range 2..1023.
REQ-002 Parameter HEADER, default 8'hA5, first byte of every packet.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  command request; one cycle is sufficient.
REQ-007 x1  in  9  rectangle left bound.
REQ-008 x2  in  9  rectangle right bound.
REQ-009 y1  in  8  rectangle top bound.
REQ-010 y2  in  8  rectangle bottom bound.
REQ-011 color  in  6  RRGGBB, 2 bits per channel.
REQ-012 tx  out  1  UART 8N1 serial line, idle high.
REQ-013 busy  out  1  high while a packet is in flight; ready = !busy.
REQ-014 done  out  1  one-cycle pulse when a packet completes.
REQ-015 byte_num  out  3  index (0..6) of the byte currently on the line; 0 when idle.

Function
REQ-016 start is accepted only on a cycle with busy=0; x1/x2/y1/y2/color are captured that cycle; start while busy=1 is ignored and never queued.
REQ-017 busy rises the cycle after acceptance; tx drives the first start bit from that same cycle.
REQ-018 Packet: 7 bytes, in order: HEADER, x1[7:0], x2[7:0], {color[5:0], x2[8], x1[8]}, y1, y2, checksum.
REQ-019 Checksum is the XOR of bytes 1..5; HEADER is excluded.
REQ-020 Each byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-021 No idle gap between bytes; the next start bit follows the stop bit immediately.
REQ-022 Packet length is exactly 70*CLKS_PER_BIT cycles from the first start bit to the end of the last stop bit.
REQ-023 FSM states IDLE -> START -> DATA -> STOP -> (START if byte_num<6, else IDLE).
REQ-024 Counters: baud 0..CLKS_PER_BIT-1 wrapping; bit 0..7; byte 0..6.
REQ-025 On the last cycle of the final stop bit: done=1 for one cycle; busy=0 on the following cycle, and start is accepted from that cycle onward.
REQ-026 Bounds are sent unchecked; x1>=x2 or y1>=y2 is transmitted as given.
REQ-027 Captured fields are stable for the whole packet regardless of input changes.

Reset
REQ-028 During reset: tx=1, busy=0, done=0, byte_num=0, FSM=IDLE, all counters 0.
REQ-029 Reset has priority over start in the same cycle.
REQ-030 Reset mid-packet aborts it; tx=1 on the next cycle, no done pulse, and the packet is not resumed.

Structure
REQ-031 Package rect_pkg holds HEADER default, PKT_LEN=7, the FSM state encoding, and the byte-3 field layout shared with the receive-side decoder.
REQ-032 Sub-module uart_tx_byte (single-byte 8N1 serializer with load/busy handshake) is natural; rect_uart_tx sequences packet bytes into it.

Verification (CLKS_PER_BIT=4)
REQ-033 x1=200, x2=300, y1=50, y2=100, color=6'h33, start pulse -> bytes A5, C8, 2C, CE, 32, 64, 7C; 280 cycles; one done pulse.
REQ-034 Sample tx at bit centres across the packet -> every start bit 0, every stop bit 1, data LSB first, no gaps.
REQ-035 start re-pulsed at cycle 100 of a packet -> ignored; exactly one packet and one done.
REQ-036 start asserted on the cycle after done with new fields -> second packet begins immediately, no idle bit time.
REQ-037 reset asserted at cycle 150 -> tx=1, busy=0 next cycle, no done; a fresh start then yields a full correct packet.
REQ-038 start and reset asserted together -> no transmission; tx stays 1.
